// File: rtl/scope_pkg.sv
// Shared types and defaults for the scope trigger/capture controller.
package scope_pkg;

    localparam int DEPTH_DEF    = 640;
    localparam int SAMPLE_W_DEF = 9;
    localparam int ADDR_W       = 10;
    localparam int AUTO_MULT    = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRE   = 3'd1,
        ARMED = 3'd2,
        POST  = 3'd3,
        DONE  = 3'd4
    } cap_state_t;

    // Circular increment over a frame of 'depth' entries.
    function automatic logic [ADDR_W-1:0] wrap_inc(
        input logic [ADDR_W-1:0] a,
        input int                depth
    );
        return (a == ADDR_W'(depth - 1)) ? '0 : a + 1'b1;
    endfunction

endpackage

// File: rtl/trig_detect.sv
// Edge-crossing detector against a threshold; owns the previous sample.
module trig_detect
    import scope_pkg::*;
#(
    parameter int SAMPLE_W = SAMPLE_W_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic [SAMPLE_W-1:0] level,
    input  logic                rising,
    input  logic                clear,
    output logic                fire
);

    logic [SAMPLE_W-1:0] r_prev;
    logic                r_prev_vld;
    logic                w_rise;
    logic                w_fall;

    assign w_rise = (r_prev < level) && (sample >= level);
    assign w_fall = (r_prev > level) && (sample <= level);
    assign fire   = sample_valid && r_prev_vld && !clear &&
                    (rising ? w_rise : w_fall);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev     <= '0;
            r_prev_vld <= 1'b0;
        end else if (clear) begin
            r_prev_vld <= 1'b0;
        end else if (sample_valid) begin
            r_prev     <= sample;
            r_prev_vld <= 1'b1;
        end
    end

endmodule

// File: rtl/trigger_capture_ctrl.sv
// Pre/post-trigger capture controller writing a double-buffered frame.
// Define TRIG_AUTO_EN to force a trigger after AUTO_MULT*DEPTH idle samples.
module trigger_capture_ctrl
    import scope_pkg::*;
#(
    parameter int DEPTH    = DEPTH_DEF,
    parameter int SAMPLE_W = SAMPLE_W_DEF,
    parameter int PRETRIG  = 320
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic [SAMPLE_W-1:0] trig_level,
    input  logic                trig_rising,
    input  logic                arm,
    input  logic                single,
    input  logic                stop,
    input  logic                frame_start,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [SAMPLE_W-1:0] wr_data,
    output logic                wr_bank,
    output logic                rd_bank,
    output logic [ADDR_W-1:0]   start_addr,
    output logic                swap,
    output logic                busy,
    output logic                triggered
);

    localparam logic [ADDR_W-1:0] L_PRE_LAST  = ADDR_W'(PRETRIG - 1);
    localparam logic [ADDR_W-1:0] L_POST_LAST = ADDR_W'(DEPTH - PRETRIG - 2);
    localparam logic [ADDR_W-1:0] L_PRE       = ADDR_W'(PRETRIG);
    localparam logic [ADDR_W-1:0] L_BACK      = ADDR_W'(DEPTH - PRETRIG);

    cap_state_t          r_state;
    cap_state_t          w_next;
    logic [ADDR_W-1:0]   r_ptr;
    logic [ADDR_W-1:0]   w_ptr_nxt;
    logic [ADDR_W-1:0]   r_cnt;
    logic [ADDR_W-1:0]   w_cnt_nxt;
    logic                w_wr;
    logic                w_trig_evt;
    logic                w_swap;
    logic                w_clear;
    logic                w_fire;
    logic                w_hit;
    logic [ADDR_W-1:0]   w_start;

    logic                r_wr_en;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [SAMPLE_W-1:0] r_wr_data;
    logic                r_wr_bank;
    logic [ADDR_W-1:0]   r_start;
    logic                r_swap;
    logic                r_trig;

    assign w_clear = (r_state == IDLE) || (r_state == DONE);

    trig_detect #(
        .SAMPLE_W (SAMPLE_W)
    ) u_detect (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample_valid (sample_valid),
        .sample       (sample),
        .level        (trig_level),
        .rising       (trig_rising),
        .clear        (w_clear),
        .fire         (w_fire)
    );

`ifdef TRIG_AUTO_EN
    localparam int AUTO_N = AUTO_MULT * DEPTH;
    localparam int AUTO_W = $clog2(AUTO_N + 1);

    logic [AUTO_W-1:0] r_auto;
    logic              w_auto_hit;

    assign w_auto_hit = sample_valid && (r_auto == AUTO_W'(AUTO_N - 1));
    assign w_hit      = w_fire || w_auto_hit;

    // Counts consecutive crossing-free samples while waiting in ARMED.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_auto <= '0;
        end else if (r_state != ARMED || stop) begin
            r_auto <= '0;
        end else if (sample_valid) begin
            r_auto <= w_hit ? '0 : r_auto + 1'b1;
        end
    end
`else
    assign w_hit = w_fire;
`endif

    // Frame start is PRETRIG entries behind the trigger, modulo DEPTH.
    assign w_start = (r_ptr >= L_PRE) ? (r_ptr - L_PRE) : (r_ptr + L_BACK);

    always_comb begin
        w_next     = r_state;
        w_ptr_nxt  = r_ptr;
        w_cnt_nxt  = r_cnt;
        w_wr       = 1'b0;
        w_trig_evt = 1'b0;
        w_swap     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (arm) begin
                    w_next    = PRE;
                    w_ptr_nxt = '0;
                    w_cnt_nxt = '0;
                end
            end
            PRE: begin
                if (sample_valid) begin
                    w_wr      = 1'b1;
                    w_ptr_nxt = wrap_inc(r_ptr, DEPTH);
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (r_cnt == L_PRE_LAST) begin
                        w_next    = ARMED;
                        w_cnt_nxt = '0;
                    end
                end
            end
            ARMED: begin
                if (sample_valid) begin
                    w_wr      = 1'b1;
                    w_ptr_nxt = wrap_inc(r_ptr, DEPTH);
                    if (w_hit) begin
                        w_trig_evt = 1'b1;
                        w_next     = POST;
                        w_cnt_nxt  = '0;
                    end
                end
            end
            POST: begin
                if (sample_valid) begin
                    w_wr      = 1'b1;
                    w_ptr_nxt = wrap_inc(r_ptr, DEPTH);
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (r_cnt == L_POST_LAST) begin
                        w_next    = DONE;
                        w_cnt_nxt = '0;
                    end
                end
            end
            DONE: begin
                if (frame_start) begin
                    w_swap    = 1'b1;
                    w_next    = single ? IDLE : PRE;
                    w_ptr_nxt = '0;
                    w_cnt_nxt = '0;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
        if (stop) begin
            w_next     = IDLE;
            w_ptr_nxt  = '0;
            w_cnt_nxt  = '0;
            w_wr       = 1'b0;
            w_trig_evt = 1'b0;
            w_swap     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_wr_bank <= 1'b1;
            r_start   <= '0;
            r_swap    <= 1'b0;
            r_trig    <= 1'b0;
        end else begin
            r_wr_en <= w_wr;
            r_swap  <= w_swap;
            r_trig  <= w_trig_evt;
            if (w_wr) begin
                r_wr_addr <= r_ptr;
                r_wr_data <= sample;
            end
            if (w_trig_evt) begin
                r_start <= w_start;
            end
            if (w_swap) begin
                r_wr_bank <= ~r_wr_bank;
            end
        end
    end

    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign wr_bank    = r_wr_bank;
    assign rd_bank    = ~r_wr_bank;
    assign start_addr = r_start;
    assign swap       = r_swap;
    assign triggered  = r_trig;
    assign busy       = (r_state == PRE) || (r_state == ARMED) ||
                        (r_state == POST);

endmodule
